dds_sweep_ctrl: RTL
===================

// Module: dds_sweep_ctrl
// PURPOSE
//   Frequency sweep sequencer for the dds core. Steps the 32-bit phase-increment word through a
//   programmed range (start/step/stop/dwell) in single, sawtooth or triangle mode.
//   Drives the dds programming port (data/we/ce). Sits between the control registers and dds.
// PARAMETERS
//   PHASE_W  32  width of DDS phase-increment word (matches dds data port)
//   DWELL_W  16  width of dwell counter (clocks per frequency step)
//   CNT_W    16  width of completed-leg counter
// PORTS
//   clk        in   1        system clock; all logic on rising edge
//   reset      in   1        asynchronous, active-low reset
//   start      in   1        1-cycle pulse; latches cfg_* and begins sweep (ignored while busy)
//   abort      in   1        synchronous stop; wins over start in the same cycle
//   cfg_start  in   PHASE_W  first frequency word
//   cfg_step   in   PHASE_W  step magnitude (unsigned)
//   cfg_stop   in   PHASE_W  upper bound of sweep (inclusive)
//   cfg_dwell  in   DWELL_W  clocks per step; 0 treated as 1
//   cfg_mode   in   2        0=single up, 1=sawtooth (repeat up), 2=triangle, 3=reserved->cfg_err
//   dds_data   out  PHASE_W  phase word to dds.data
//   dds_we     out  1        1-cycle write strobe to dds.we
//   dds_ce     out  1        dds clock enable
//   busy       out  1        high from cycle after start until DONE/abort
//   done       out  1        1-cycle pulse at end of single-mode sweep
//   cfg_err    out  1        sticky; set on rejected start, cleared by next accepted start
//   leg_count  out  CNT_W    legs completed since last accepted start; wraps at 2^CNT_W
// BEHAVIOUR
//   Reset (async, reset=0): all outputs 0, FSM=IDLE, latched config cleared.
//   FSM: IDLE -> LOAD -> DWELL -> (STEP -> LOAD | DONE) ; all outputs registered.
//   IDLE: start=1 & abort=0 & valid config -> latch cfg_*, cur=cfg_start, dir=up, leg_count=0,
//     cfg_err=0, -> LOAD. Invalid (cfg_start>cfg_stop or cfg_mode=3): cfg_err=1, stay IDLE.
//   LOAD: dds_data<=cur, dds_we=1 for exactly one cycle, dds_ce=1; busy=1. First dds_we is the
//     cycle after start is sampled.
//   DWELL: consecutive dds_we pulses exactly max(cfg_dwell,1) clocks apart (LOAD cycle counts).
//   STEP: next = cur+step (up) / cur-step (down), computed PHASE_W+1 bits to catch carry/borrow.
//     Up leg ends when carry or next>stop; down leg ends when borrow or next<start.
//     In range: cur=next, -> LOAD.
//     Leg end, leg_count++ then: mode0 -> DONE; mode1 -> cur=start, -> LOAD;
//     mode2 -> dir flips, cur=cur-/+step applied in new dir; if that is also out of range, cur unchanged.
//     Endpoints never written twice consecutively except in the unchanged-cur case.
//   cfg_step=0: mode0 -> DONE after first dwell (leg_count=1); modes1/2 hold start until abort, no leg_count++.
//   DONE: done=1 one cycle, busy=0, -> IDLE. dds_data holds last word, dds_ce stays 1.
//   abort (any state): next cycle FSM=IDLE, busy=0, dds_ce=0, dds_we=0, no done pulse;
//     dds_data and leg_count hold. abort in IDLE only clears dds_ce.
//   start while busy: ignored, no cfg_err. Config inputs sampled only on accepted start.
//   Reset mid-sweep: immediate return to reset values; no we glitch.
// TESTING
//   1 mode0 start=100 step=30 stop=200 dwell=4 -> we at words 100,130,160,190 spaced 4 clks; done 4 clks after last we; leg_count=1.
//   2 mode2 same cfg, dwell=1 -> words 100,130,160,190,160,130,100,130,...; leg_count increments at 190 and 100 turns.
//   3 mode1 start=0xFFFFFF00 step=0x80 stop=0xFFFFFFFF -> FFFFFF00,FFFFFF80,FFFFFF00 (carry ends leg, no wrap to 0).
//   4 cfg_start=500 cfg_stop=400 start -> cfg_err=1, busy=0, no dds_we; next valid start clears cfg_err.
//   5 abort in DWELL of mode1 -> next clk busy=0, dds_ce=0, no further dds_we; start+abort same cycle in IDLE -> no sweep.
//   6 reset low mid-LOAD -> dds_we, dds_ce, busy, dds_data all 0 asynchronously; second start during busy ignored.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency sweep sequencer for the dds core.
// Steps the phase-increment word from a latched start value towards a latched
// stop value in single, sawtooth or triangle mode. Each new word is written to
// the dds once (dds_we), then held for max(cfg_dwell,1) clocks before the next.
//
// Control handshake: start and abort are single-cycle request pulses with no
// ready/ack. start is accepted only in IDLE with abort low and a valid config;
// abort is honoured in every state and always wins over start in the same cycle.
// busy reports the sweep being active; done is a one-cycle completion pulse.
//
// The step decision is taken on the last dwell clock of each word, so the next
// word lands exactly one dwell period after the previous one (dwell=1 writes
// every clock). All outputs come straight from registers.
module dds_sweep_ctrl #(
    parameter int PHASE_W = 32,
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [PHASE_W-1:0] cfg_start,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [PHASE_W-1:0] cfg_stop,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    output logic [PHASE_W-1:0] dds_data,
    output logic               dds_we,
    output logic               dds_ce,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   leg_count,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PHASE_W-1:0] r_start, r_step, r_stop, r_data;
    logic [PHASE_W-1:0] w_start_nxt, w_step_nxt, w_stop_nxt, w_data_nxt;
    logic [DWELL_W-1:0] r_dwell, r_cnt, w_dwell_nxt, w_cnt_nxt;
    logic [1:0]         r_mode, w_mode_nxt;
    logic               r_dir, w_dir_nxt;  // 0 = up, 1 = down
    logic               r_we, r_ce, r_busy, r_done, r_err;
    logic               w_we_nxt, w_ce_nxt, w_busy_nxt, w_done_nxt, w_err_nxt;
    logic [CNT_W-1:0]   r_leg, w_leg_nxt;

    // One extra bit on the arithmetic exposes carry (up) and borrow (down).
    logic [PHASE_W:0]   w_sum, w_diff;
    logic               w_up_out, w_dn_out, w_in_range, w_last;
    logic [DWELL_W-1:0] w_dwell_m1;

    assign w_sum      = {1'b0, r_data} + {1'b0, r_step};
    assign w_diff     = {1'b0, r_data} - {1'b0, r_step};
    assign w_up_out   = w_sum[PHASE_W] | (w_sum[PHASE_W-1:0] > r_stop);
    assign w_dn_out   = w_diff[PHASE_W] | (w_diff[PHASE_W-1:0] < r_start);
    assign w_in_range = r_dir ? !w_dn_out : !w_up_out;
    assign w_dwell_m1 = (r_dwell == '0) ? '0 : r_dwell - 1'b1;
    assign w_last     = (r_cnt == w_dwell_m1);

    // Next-state and next-output logic for the sweep FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = r_start;
        w_step_nxt  = r_step;
        w_stop_nxt  = r_stop;
        w_dwell_nxt = r_dwell;
        w_mode_nxt  = r_mode;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_we_nxt    = 1'b0;
        w_ce_nxt    = r_ce;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_leg_nxt   = r_leg;
        case (r_state)
            S_IDLE: begin
                if (abort) begin
                    w_ce_nxt = 1'b0;
                end else if (start) begin
                    if ((cfg_start > cfg_stop) || (cfg_mode == 2'd3)) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_start_nxt = cfg_start;
                        w_step_nxt  = cfg_step;
                        w_stop_nxt  = cfg_stop;
                        w_dwell_nxt = cfg_dwell;
                        w_mode_nxt  = cfg_mode;
                        w_data_nxt  = cfg_start;
                        w_cnt_nxt   = '0;
                        w_dir_nxt   = 1'b0;
                        w_we_nxt    = 1'b1;
                        w_ce_nxt    = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_err_nxt   = 1'b0;
                        w_leg_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD, S_DWELL: begin
                if (abort) begin
                    w_busy_nxt  = 1'b0;
                    w_ce_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (!w_last) begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_state_nxt = S_DWELL;
                end else if (r_step == '0) begin
                    // A zero step can never leave the start word: single mode
                    // finishes one leg, repeating modes park on it until abort.
                    if (r_mode == 2'd0) begin
                        w_leg_nxt   = r_leg + 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DWELL;
                    end
                end else if (w_in_range) begin
                    w_data_nxt  = r_dir ? w_diff[PHASE_W-1:0] : w_sum[PHASE_W-1:0];
                    w_cnt_nxt   = '0;
                    w_we_nxt    = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_leg_nxt = r_leg + 1'b1;
                    w_cnt_nxt = '0;
                    case (r_mode)
                        2'd0: begin
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_DONE;
                        end
                        2'd1: begin
                            w_data_nxt  = r_start;
                            w_we_nxt    = 1'b1;
                            w_state_nxt = S_LOAD;
                        end
                        default: begin
                            // Turn around; if even the first step back leaves
                            // the range, rewrite the current endpoint instead.
                            w_dir_nxt   = !r_dir;
                            w_we_nxt    = 1'b1;
                            w_state_nxt = S_LOAD;
                            if (r_dir)
                                w_data_nxt = w_up_out ? r_data : w_sum[PHASE_W-1:0];
                            else
                                w_data_nxt = w_dn_out ? r_data : w_diff[PHASE_W-1:0];
                        end
                    endcase
                end
            end
            S_DONE: begin
                if (abort) w_ce_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers; reset returns everything to zero at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_start <= '0;
            r_step  <= '0;
            r_stop  <= '0;
            r_dwell <= '0;
            r_mode  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_we    <= 1'b0;
            r_ce    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_leg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_step  <= w_step_nxt;
            r_stop  <= w_stop_nxt;
            r_dwell <= w_dwell_nxt;
            r_mode  <= w_mode_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_we    <= w_we_nxt;
            r_ce    <= w_ce_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_leg   <= w_leg_nxt;
        end
    end

    assign dds_data  = r_data;
    assign dds_we    = r_we;
    assign dds_ce    = r_ce;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_err;
    assign leg_count = r_leg;
    assign dbg_state = r_state;

endmodule
